// File: rtl/hilbert_framer.sv
// hilbert_framer: tags strobed complex antenna samples with a frame tick index.
// Optional FRAME_CHECK_EN: in RUN, framed_i is checked against the tick count.
module hilbert_framer #(
  parameter int WIDTH = 24,
  parameter int TICKS = 12,
  parameter int TBITS = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             locked_i,
  input  logic             strobe_i,
  input  logic             framed_i,
  input  logic [WIDTH-1:0] sig_re_i,
  input  logic [WIDTH-1:0] sig_im_i,
  output logic             valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic [TBITS-1:0] tick_o,
  output logic [WIDTH-1:0] re_o,
  output logic [WIDTH-1:0] im_o,
  output logic [15:0]      frames_o,
  output logic             error_o,
  output logic             synced_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [TBITS-1:0] LastTick = TBITS'(TICKS - 1);

  state_e           state_q, state_d;
  logic [TBITS-1:0] tick_q, tick_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [TBITS-1:0] otick_q, otick_d;
  logic [WIDTH-1:0] re_q, re_d;
  logic [WIDTH-1:0] im_q, im_d;
  logic [15:0]      frames_q, frames_d;
`ifdef FRAME_CHECK_EN
  logic             err_q, err_d;
`endif

  // accept: sample goes out next cycle tagged with acc_tick
  logic             accept;
  logic [TBITS-1:0] acc_tick;

  function automatic logic [TBITS-1:0] next_tick(input logic [TBITS-1:0] t);
    return (t == LastTick) ? '0 : t + TBITS'(1);
  endfunction

  // FSM transitions and sample acceptance
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    accept   = 1'b0;
    acc_tick = tick_q;
`ifdef FRAME_CHECK_EN
    err_d    = 1'b0;
`endif
    if (!locked_i) begin
      state_d = IDLE;
      tick_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SYNC;
          tick_d  = '0;
        end
        SYNC: begin
          if (strobe_i && framed_i) begin
            state_d  = RUN;
            accept   = 1'b1;
            acc_tick = '0;
            tick_d   = next_tick('0);
          end
        end
        RUN: begin
          if (strobe_i) begin
`ifdef FRAME_CHECK_EN
            if (framed_i && tick_q != '0) begin
              // early frame marker: realign on this sample
              err_d    = 1'b1;
              accept   = 1'b1;
              acc_tick = '0;
              tick_d   = next_tick('0);
            end else if (!framed_i && tick_q == '0) begin
              // missing frame marker: drop and hunt again
              err_d    = 1'b1;
              state_d  = SYNC;
              tick_d   = '0;
            end else begin
              accept   = 1'b1;
              tick_d   = next_tick(tick_q);
            end
`else
            accept = 1'b1;
            tick_d = next_tick(tick_q);
`endif
          end
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  // output register next-state; data holds when nothing is accepted
  always_comb begin
    valid_d  = accept;
    first_d  = accept && (acc_tick == '0);
    last_d   = accept && (acc_tick == LastTick);
    otick_d  = otick_q;
    re_d     = re_q;
    im_d     = im_q;
    frames_d = frames_q;
    if (accept) begin
      otick_d = acc_tick;
      re_d    = sig_re_i;
      im_d    = sig_im_i;
      if (acc_tick == LastTick) begin
        frames_d = frames_q + 16'd1;
      end
    end
  end

  // state and output registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      otick_q  <= '0;
      re_q     <= '0;
      im_q     <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      last_q   <= last_d;
      otick_q  <= otick_d;
      re_q     <= re_d;
      im_q     <= im_d;
      frames_q <= frames_d;
    end
  end

`ifdef FRAME_CHECK_EN
  // one-cycle framing-error pulse
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  assign valid_o  = valid_q;
  assign first_o  = first_q;
  assign last_o   = last_q;
  assign tick_o   = otick_q;
  assign re_o     = re_q;
  assign im_o     = im_q;
  assign frames_o = frames_q;
  assign synced_o = (state_q == RUN);

endmodule

// File: tb/tb_hilbert_framer.sv
// tb_hilbert_framer: scoreboard bench for hilbert_framer.
// Build with FRAME_CHECK_EN to exercise the framing-check scenarios.
module tb_hilbert_framer;

  localparam int W  = 24;
  localparam int T  = 12;
  localparam int TB = 4;

  logic          clk = 1'b0;
  logic          rst, locked, strobe, framed;
  logic [W-1:0]  sre, sim;
  logic          valid, first, last, err, synced;
  logic [TB-1:0] tick;
  logic [W-1:0]  reo, imo;
  logic [15:0]   frames;

  hilbert_framer #(.WIDTH(W), .TICKS(T), .TBITS(TB)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .locked_i(locked),
    .strobe_i(strobe),
    .framed_i(framed),
    .sig_re_i(sre),
    .sig_im_i(sim),
    .valid_o (valid),
    .first_o (first),
    .last_o  (last),
    .tick_o  (tick),
    .re_o    (reo),
    .im_o    (imo),
    .frames_o(frames),
    .error_o (err),
    .synced_o(synced)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          tick;
    bit          first;
    bit          last;
    logic [W-1:0] re;
    logic [W-1:0] im;
    int          frames;
  } exp_t;

  exp_t q[$];
  int   eq[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_frames = 0;
  logic [W-1:0]  h_re = '0, h_im = '0;
  logic [TB-1:0] h_tick = '0;
  exp_t m;
  int   ec;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: pop expected samples / error pulses as the DUT presents them
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid_o=1 expected 0 (cycle %0d)", cyc);
      end else begin
        m = q.pop_front();
        chk("latency", 64'(cyc), 64'(m.cyc));
        chk("tick_o", 64'(tick), 64'(m.tick));
        chk("first_o", 64'(first), 64'(m.first));
        chk("last_o", 64'(last), 64'(m.last));
        chk("re_o", 64'(reo), 64'(m.re));
        chk("im_o", 64'(imo), 64'(m.im));
        chk("frames_o", 64'(frames), 64'(m.frames));
        h_re   = m.re;
        h_im   = m.im;
        h_tick = TB'(m.tick);
      end
    end else if (valid === 1'b0) begin
      chk("hold", {tick, reo, imo}, {h_tick, h_re, h_im});
    end else begin
      chk("valid_known", 64'(valid), 64'(0));
    end
    if (err === 1'b1) begin
      if (eq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_error: got error_o=1 expected 0 (cycle %0d)", cyc);
      end else begin
        ec = eq.pop_front();
        chk("error_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  // one strobe; et<0 means the sample must be dropped, xe an error pulse
  task automatic samp(input bit fr, input int et, input bit xe,
                      input logic [W-1:0] re, input logic [W-1:0] im);
    exp_t e;
    strobe = 1'b1;
    framed = fr;
    sre    = re;
    sim    = im;
    if (et >= 0) begin
      if (et == T - 1) exp_frames++;
      e.cyc    = cyc + 1;
      e.tick   = et;
      e.first  = (et == 0);
      e.last   = (et == T - 1);
      e.re     = re;
      e.im     = im;
      e.frames = exp_frames;
      q.push_back(e);
    end
    if (xe) eq.push_back(cyc + 1);
    @(posedge clk);
    #1;
    strobe = 1'b0;
    framed = 1'b0;
  endtask

  task automatic idle(input int n, input bit fr);
    repeat (n) begin
      framed = fr;
      @(posedge clk);
      #1;
    end
    framed = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 64'(valid), 64'(0));
    chk({nm, "_first"}, 64'(first), 64'(0));
    chk({nm, "_last"}, 64'(last), 64'(0));
    chk({nm, "_tick"}, 64'(tick), 64'(0));
    chk({nm, "_re"}, 64'(reo), 64'(0));
    chk({nm, "_im"}, 64'(imo), 64'(0));
    chk({nm, "_frames"}, 64'(frames), 64'(0));
    chk({nm, "_error"}, 64'(err), 64'(0));
    chk({nm, "_synced"}, 64'(synced), 64'(0));
  endtask

  function automatic logic [W-1:0] rv(input int i);
    return W'(24'h100000 + i);
  endfunction

  function automatic logic [W-1:0] iv(input int i);
    return W'(24'h200000 + i * 3);
  endfunction

  initial begin
    rst    = 1'b1;
    locked = 1'b0;
    strobe = 1'b0;
    framed = 1'b0;
    sre    = '0;
    sim    = '0;
    @(posedge clk);
    #1;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    locked = 1'b1;
    idle(2, 1'b0);
    chk("sync_not_run", 64'(synced), 64'(0));

    // strobe every 2 cycles, framed every 12th; framed_i also on some gaps
    for (int i = 0; i < 36; i++) begin
      samp(i % 12 == 0, i % 12, 1'b0, rv(i), iv(i));
      idle(1, i % 3 == 1);
    end
    idle(2, 1'b0);
    chk("frames_after_36", 64'(frames), 64'(3));
    chk("synced_run", 64'(synced), 64'(1));

    // back-to-back strobes for 24 cycles
    for (int i = 0; i < 24; i++) samp(i % 12 == 0, i % 12, 1'b0, rv(100 + i), iv(i));
    idle(2, 1'b0);
    chk("frames_after_b2b", 64'(frames), 64'(5));

`ifdef FRAME_CHECK_EN
    // early marker on the 7th strobe: resync as tick 0
    for (int i = 0; i < 6; i++) samp(i == 0, i, 1'b0, rv(200 + i), iv(i));
    samp(1'b1, 0, 1'b1, rv(206), iv(6));
    idle(1, 1'b0);
    chk("frames_unchanged_early", 64'(frames), 64'(5));
    for (int t = 1; t < T; t++) samp(1'b0, t, 1'b0, rv(210 + t), iv(t));
    // missing marker at expected tick 0: drop and back to SYNC
    samp(1'b0, -1, 1'b1, rv(230), iv(0));
    chk("synced_drop", 64'(synced), 64'(0));
    samp(1'b1, 0, 1'b0, rv(231), iv(1));
    chk("synced_restore", 64'(synced), 64'(1));
`else
    // framed_i ignored in RUN: tick free-runs
    for (int i = 0; i < T; i++) samp(i == 0 || i == 6, i, 1'b0, rv(200 + i), iv(i));
    samp(1'b0, 0, 1'b0, rv(231), iv(1));
    chk("synced_freerun", 64'(synced), 64'(1));
`endif
    for (int t = 1; t < T; t++) samp(1'b0, t, 1'b0, rv(240 + t), iv(t));
    idle(2, 1'b0);
    chk("frames_after_check", 64'(frames), 64'(7));

    // lose lock, resync: unframed strobes in SYNC are discarded
    locked = 1'b0;
    idle(1, 1'b0);
    chk("unlocked_idle", 64'(synced), 64'(0));
    locked = 1'b1;
    idle(1, 1'b0);
    for (int i = 0; i < 5; i++) samp(1'b0, -1, 1'b0, rv(300 + i), iv(i));
    chk("sync_discard", 64'(synced), 64'(0));
    samp(1'b1, 0, 1'b0, 24'hABCDEF, 24'h123456);
    for (int t = 1; t < 5; t++) samp(1'b0, t, 1'b0, rv(310 + t), iv(t));

    // lock dropped at tick 5
    locked = 1'b0;
    samp(1'b0, -1, 1'b0, rv(320), iv(0));
    chk("lockdrop_idle", 64'(synced), 64'(0));
    chk("lockdrop_frames", 64'(frames), 64'(7));
    locked = 1'b1;
    idle(1, 1'b0);
    samp(1'b1, 0, 1'b0, rv(330), iv(0));
    for (int t = 1; t < 8; t++) samp(1'b0, t, 1'b0, rv(330 + t), iv(t));

    // reset at tick 8 abandons the partial frame
    rst = 1'b1;
    samp(1'b0, -1, 1'b0, rv(340), iv(0));
    h_re       = '0;
    h_im       = '0;
    h_tick     = '0;
    exp_frames = 0;
    chk_zero("midreset");
    rst = 1'b0;
    idle(1, 1'b0);
    samp(1'b0, -1, 1'b0, rv(350), iv(0));
    chk("reset_needs_frame", 64'(synced), 64'(0));
    samp(1'b1, 0, 1'b0, rv(351), iv(1));
    samp(1'b0, 1, 1'b0, rv(352), iv(2));
    idle(3, 1'b0);
    chk("post_reset_synced", 64'(synced), 64'(1));
    chk("post_reset_frames", 64'(frames), 64'(0));

    chk("queue_drain", 64'(q.size()), 64'(0));
    chk("error_drain", 64'(eq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
